alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready arbiter in front of a shared external ALU.
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_operandA,
  input  logic [31:0] req0_operandB,
  input  logic [2:0]  req0_command,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_operandA,
  input  logic [31:0] req1_operandB,
  input  logic [2:0]  req1_command,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [2:0]  alu_command,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carryout,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_id
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic        stats_clear,
  output logic [31:0] grant_count0,
  output logic [31:0] grant_count1
`endif
);

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_id_q, rsp_id_d;
  logic        last_grant_q, last_grant_d;

  logic slot_free;
  logic any_valid;
  logic both_valid;
  logic grant;
  logic accept;

  assign slot_free  = ~rsp_valid_q | rsp_ready;
  assign any_valid  = req0_valid | req1_valid;
  assign both_valid = req0_valid & req1_valid;

  // On a tie, round-robin favours whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      both_valid:
        grant = (PRIO_MODE != 0) ? 1'b0 : ~last_grant_q;
      (req1_valid & ~req0_valid):
        grant = 1'b1;
      default:
        grant = 1'b0;
    endcase
  end

  assign accept     = slot_free & any_valid & ~reset;
  assign req0_ready = accept & ~grant & req0_valid;
  assign req1_ready = accept & grant & req1_valid;

  always_comb begin
    alu_operandA = '0;
    alu_operandB = '0;
    alu_command  = 3'b000;
    if (any_valid) begin
      if (grant) begin
        alu_operandA = req1_operandA;
        alu_operandB = req1_operandB;
        alu_command  = req1_command;
      end else begin
        alu_operandA = req0_operandA;
        alu_operandB = req0_operandB;
        alu_command  = req0_command;
      end
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_result;
      rsp_carry_d  = alu_carryout;
      rsp_zero_d   = alu_zero;
      rsp_ovf_d    = alu_overflow;
      rsp_id_d     = grant;
      last_grant_d = grant;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carryout = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_id       = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  // Clear wins over a same-cycle increment; counts saturate.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clear) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (req0_ready && cnt0_q != '1)
        cnt0_d = cnt0_q + 32'd1;
      if (req1_ready && cnt1_q != '1)
        cnt1_d = cnt1_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_count0 = cnt0_q;
  assign grant_count1 = cnt1_q;
`endif

endmodule
